// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART baud generator and
//               its prescaler: oversample limits, oversample mode enum and
//               the default integer divisor width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned UART_DIV_W_DEFAULT = 12;

  // Last sample index within a bit for each oversample mode
  localparam logic [3:0] UART_OSR16_LAST = 4'd15;
  localparam logic [3:0] UART_OSR8_LAST  = 4'd7;

  typedef enum logic {
    OSR_X16 = 1'b0,
    OSR_X8  = 1'b1
  } osr_mode_t;

  function automatic logic [3:0] osr_last(input osr_mode_t mode);
    return (mode == OSR_X8) ? UART_OSR8_LAST : UART_OSR16_LAST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_presc.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_presc
// Description : Sample-period prescaler. Counts 0..limit and flags the last
//               clock of each sample period with a combinational boundary
//               strobe. A fractional accumulator stretches a period by one
//               clock whenever it carries; with a zero fraction the period is
//               exactly div+1 clocks and the accumulator folds away.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               i_en       - enable; low clears counter and accumulator
//               i_div_q    - active integer divisor
//               i_frac_q   - active fractional divisor
//               o_boundary - high during the last clock of a sample period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_presc
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = UART_DIV_W_DEFAULT,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_div_q,
  input  logic [FRAC_W-1:0] i_frac_q,
  output logic              o_boundary
);

  // One extra bit so a stretched period (div+1) never wraps
  logic [DIV_W:0]  r_pre;
  logic [FRAC_W-1:0] r_acc;
  logic            r_ext;   // current period is stretched by one clock

  logic [DIV_W:0]  w_limit;
  logic [FRAC_W:0] w_sum;

  assign w_limit    = {1'b0, i_div_q} + {{DIV_W{1'b0}}, r_ext};
  assign w_sum      = {1'b0, r_acc} + {1'b0, i_frac_q};
  assign o_boundary = i_en && (r_pre == w_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_acc <= '0;
      r_ext <= 1'b0;
    end else if (!i_en) begin
      r_pre <= '0;
      r_acc <= '0;
      r_ext <= 1'b0;
    end else if (o_boundary) begin
      r_pre <= '0;
      r_acc <= w_sum[FRAC_W-1:0];
      r_ext <= w_sum[FRAC_W];
    end else begin
      r_pre <= r_pre + {{DIV_W{1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Parametrised UART baud generator. Emits a registered
//               oversample tick and a registered per-bit tick (x16 or x8
//               oversampling). New divisor/mode settings are held pending and
//               switched in only at a sample boundary (or at once while
//               disabled), restarting the bit, and acknowledged with a pulse.
// Options     : define UART_BAUD_FRAC_EN to add the fractional divisor input
//               i_frac_in; average period becomes div+1+frac/2^FRAC_W.
// Ports       : clk           - system clock, rising edge
//               rst_n         - asynchronous active-low reset
//               i_en          - generator enable
//               i_div_in      - new integer divisor
//               i_osr_sel     - new oversample mode (0 = x16, 1 = x8)
//               i_div_load    - capture new settings into pending
//               i_frac_in     - new fractional divisor (option only)
//               o_sample_tick - one-clock pulse per sample period
//               o_bit_tick    - one-clock pulse on the last sample of a bit
//               o_os_cnt      - sample index within the bit
//               o_load_ack    - pulse when pending settings became active
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned      DIV_W   = UART_DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] DIV_RST = '0,
  parameter int unsigned      FRAC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_div_in,
  input  logic              i_osr_sel,
  input  logic              i_div_load,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] i_frac_in,
`endif
  output logic              o_sample_tick,
  output logic              o_bit_tick,
  output logic [3:0]        o_os_cnt,
  output logic              o_load_ack
);

  logic [DIV_W-1:0]  r_div_q;
  osr_mode_t         r_osr_q;
  logic [DIV_W-1:0]  r_pend_div;
  osr_mode_t         r_pend_osr;
  logic              r_pend;
  logic [3:0]        r_os_cnt;
  logic              r_sample_tick;
  logic              r_bit_tick;
  logic              r_load_ack;

  logic              w_boundary;
  logic              w_apply;
  logic [3:0]        w_last;
  logic [FRAC_W-1:0] w_frac_q;

  assign w_last  = osr_last(r_osr_q);
  // While disabled there is no boundary to wait for, so apply immediately
  assign w_apply = r_pend && (!i_en || w_boundary);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_frac_q;
  logic [FRAC_W-1:0] r_pend_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frac_q    <= '0;
      r_pend_frac <= '0;
    end else begin
      if (w_apply)    r_frac_q    <= r_pend_frac;
      if (i_div_load) r_pend_frac <= i_frac_in;
    end
  end

  assign w_frac_q = r_frac_q;
`else
  assign w_frac_q = '0;
`endif

  uart_baud_presc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_presc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_div_q    (r_div_q),
    .i_frac_q   (w_frac_q),
    .o_boundary (w_boundary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q       <= DIV_RST;
      r_osr_q       <= OSR_X16;
      r_pend_div    <= '0;
      r_pend_osr    <= OSR_X16;
      r_pend        <= 1'b0;
      r_os_cnt      <= '0;
      r_sample_tick <= 1'b0;
      r_bit_tick    <= 1'b0;
      r_load_ack    <= 1'b0;
    end else begin
      // Ticks of an apply boundary still belong to the old configuration
      r_sample_tick <= w_boundary;
      r_bit_tick    <= w_boundary && (r_os_cnt == w_last);
      r_load_ack    <= w_apply;

      if (!i_en) begin
        r_os_cnt <= '0;
      end else if (w_boundary) begin
        r_os_cnt <= (w_apply || (r_os_cnt == w_last)) ? 4'd0 : r_os_cnt + 4'd1;
      end

      if (w_apply) begin
        r_div_q <= r_pend_div;
        r_osr_q <= r_pend_osr;
      end

      // A load on an apply edge refills pending, so pend stays set
      if (i_div_load) begin
        r_pend_div <= i_div_in;
        r_pend_osr <= osr_mode_t'(i_osr_sel);
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign o_sample_tick = r_sample_tick;
  assign o_bit_tick    = r_bit_tick;
  assign o_os_cnt      = r_os_cnt;
  assign o_load_ack    = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_gen
// Description : Self-checking bench for uart_baud_gen. A cycle-level model
//               counts enabled edges and schedules sample boundaries from the
//               divisor arithmetic; every cycle the DUT outputs are compared
//               against it. Directed sequences add hand-computed checks on
//               tick spacing, load acknowledge, enable gating and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_gen;

  localparam int DIV_W  = 12;
  localparam int FRAC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_en = 1'b0;
  logic [DIV_W-1:0] i_div_in = '0;
  logic             i_osr_sel = 1'b0;
  logic             i_div_load = 1'b0;
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] i_frac_in = '0;
`endif
  logic             o_sample_tick;
  logic             o_bit_tick;
  logic [3:0]       o_os_cnt;
  logic             o_load_ack;

  int n_checks = 0;
  int n_fail   = 0;

  uart_baud_gen #(
    .DIV_W   (DIV_W),
    .DIV_RST ('0),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_div_in      (i_div_in),
    .i_osr_sel     (i_osr_sel),
    .i_div_load    (i_div_load),
`ifdef UART_BAUD_FRAC_EN
    .i_frac_in     (i_frac_in),
`endif
    .o_sample_tick (o_sample_tick),
    .o_bit_tick    (o_bit_tick),
    .o_os_cnt      (o_os_cnt),
    .o_load_ack    (o_load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_n: enabled edges since the last restart; m_nb: edge index of the next
  // sample boundary; m_k: boundaries since restart.
  int m_n, m_nb, m_k, m_acc, m_carry, m_div, m_L, m_frac;
  int m_pend, m_pd, m_pl, m_pf;
  logic e_sample, e_bit, e_ack;
  int e_os;

  task automatic model_reset();
    m_n = 0; m_k = 0; m_acc = 0; m_carry = 0;
    m_div = 0; m_L = 15; m_frac = 0; m_nb = 1;
    m_pend = 0; m_pd = 0; m_pl = 15; m_pf = 0;
    e_sample = 0; e_bit = 0; e_ack = 0; e_os = 0;
  endtask

  task automatic model_apply();
    m_div = m_pd; m_L = m_pl; m_frac = m_pf; m_pend = 0; e_ack = 1;
  endtask

  task automatic model_step();
    e_sample = 0; e_bit = 0; e_ack = 0;
    if (!i_en) begin
      if (m_pend != 0) model_apply();
      m_n = 0; m_k = 0; m_acc = 0;
      m_nb = m_div + 1;
    end else begin
      m_n++;
      if (m_n == m_nb) begin
        e_sample = 1;
        m_k++;
        e_bit = ((m_k % (m_L + 1)) == 0);
        m_acc   = m_acc + m_frac;
        m_carry = m_acc / (1 << FRAC_W);
        m_acc   = m_acc % (1 << FRAC_W);
        if (m_pend != 0) begin
          model_apply();
          m_n = 0; m_k = 0;
        end
        m_nb = m_n + m_div + 1 + m_carry;
      end
    end
    e_os = m_k % (m_L + 1);
    if (i_div_load) begin
      m_pend = 1;
      m_pd   = int'(i_div_in);
      m_pl   = i_osr_sel ? 7 : 15;
`ifdef UART_BAUD_FRAC_EN
      m_pf   = int'(i_frac_in);
`endif
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sample_tick", o_sample_tick, e_sample);
      check("bit_tick",    o_bit_tick,    e_bit);
      check("os_cnt",      o_os_cnt,      e_os);
      check("load_ack",    o_load_ack,    e_ack);
    end
  end

  // ---------------- directed stimulus ----------------
  // Waits for sel (0 sample_tick, 1 bit_tick, 2 load_ack); n = negedges waited
  task automatic wait_sig(input int sel, input int limit, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    while (!s && n < limit) begin
      @(negedge clk);
      n++;
      s = (sel == 0) ? o_sample_tick : (sel == 1) ? o_bit_tick : o_load_ack;
    end
    if (!s) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_sig%0d timeout after %0d cycles", sel, n);
    end
  endtask

  task automatic load_cfg(input int d, input logic osr);
    i_div_in   = DIV_W'(d);
    i_osr_sel  = osr;
    i_div_load = 1'b1;
    @(negedge clk);
    i_div_load = 1'b0;
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check("rst_sample", o_sample_tick, 0);
    check("rst_bit",    o_bit_tick,    0);
    check("rst_os",     o_os_cnt,      0);
    check("rst_ack",    o_load_ack,    0);
    rst_n = 1'b1;
    @(negedge clk);

    // D=3, x16 loaded while disabled
    load_cfg(3, 1'b0);
    @(negedge clk);
    check("t1_ack", o_load_ack, 1);
    i_en = 1'b1;
    wait_sig(0, 20, n);  check("t1_first_tick", n, 4);
    wait_sig(1, 200, n); check("t1_first_bit", n, 60);
    wait_sig(1, 200, n); check("t1_bit_period", n, 64);

    // D=0, x8
    i_en = 1'b0;
    load_cfg(0, 1'b1);
    @(negedge clk);
    check("t2_ack", o_load_ack, 1);
    i_en = 1'b1;
    wait_sig(0, 20, n); check("t2_first_tick", n, 1);
    wait_sig(1, 40, n); check("t2_first_bit", n, 7);
    wait_sig(1, 40, n); check("t2_bit_period", n, 8);

    // D=9 running, reload D=1 at pre=4
    i_en = 1'b0;
    load_cfg(9, 1'b0);
    @(negedge clk);
    i_en = 1'b1;
    wait_sig(0, 40, n); check("t3_first_tick", n, 10);
    repeat (4) @(negedge clk);
    load_cfg(1, 1'b0);
    wait_sig(0, 40, n); check("t3_old_period_end", n, 5);
    check("t3_ack", o_load_ack, 1);
    check("t3_os_restart", o_os_cnt, 0);
    wait_sig(0, 40, n); check("t3_new_period", n, 2);
    check("t3_os_next", o_os_cnt, 1);

    // Two loads before one boundary: last wins, single ack
    load_cfg(9, 1'b0);
    wait_sig(2, 10, n); check("t4_setup_ack", n, 1);
    i_div_in = DIV_W'(5); i_div_load = 1'b1;
    @(negedge clk);
    i_div_in = DIV_W'(2);
    @(negedge clk);
    i_div_load = 1'b0;
    wait_sig(2, 40, n); check("t4_ack_delay", n, 8);
    wait_sig(0, 40, n); check("t4_last_wins", n, 3);
    check("t4_single_ack", o_load_ack, 0);
    // Load exactly on an apply edge: applied one boundary later
    load_cfg(4, 1'b0);
    @(negedge clk);
    i_div_in = DIV_W'(6); i_div_load = 1'b1;
    @(negedge clk);
    i_div_load = 1'b0;
    check("t4_coincide_ack", o_load_ack, 1);
    check("t4_coincide_tick", o_sample_tick, 1);
    wait_sig(2, 40, n); check("t4_second_apply", n, 5);
    wait_sig(0, 40, n); check("t4_final_period", n, 7);

    // Enable drop at os_cnt=7, re-enable, async reset mid-bit
    n = 0;
    while (o_os_cnt != 4'd7 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_os7", o_os_cnt, 7);
    i_en = 1'b0;
    @(negedge clk);
    check("t5_dis_os", o_os_cnt, 0);
    check("t5_dis_tick", o_sample_tick, 0);
    repeat (2) @(negedge clk);
    i_en = 1'b1;
    wait_sig(0, 40, n); check("t5_reenable", n, 7);
    load_cfg(20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_os", o_os_cnt, 0);
    check("t5_rst_tick", o_sample_tick, 0);
    check("t5_rst_bit", o_bit_tick, 0);
    check("t5_rst_ack", o_load_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 10, n); check("t5_post_rst_div", n, 1);
    repeat (30) @(negedge clk);

`ifdef UART_BAUD_FRAC_EN
    // D=3, F=8: periods 4,4,5,4,5...
    i_en = 1'b0;
    i_frac_in = 4'd8;
    load_cfg(3, 1'b0);
    @(negedge clk);
    check("t6_ack", o_load_ack, 1);
    i_en = 1'b1;
    wait_sig(0, 20, n);  check("t6_p1", n, 4);
    wait_sig(0, 20, n);  check("t6_p2", n, 4);
    wait_sig(0, 20, n);  check("t6_p3", n, 5);
    wait_sig(1, 200, n); check("t6_first_bit", n, 58);
    wait_sig(1, 200, n); check("t6_bit_period", n, 72);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
